// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared state encoding, port indices and latency bounds for the
//           two-port memory arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int CNT_W       = 3;
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

    function automatic logic lat_ok(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ============================================================================
// Module  : rr_pick2
// Purpose : Combinational two-way round-robin selector.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic idx
);

    always_comb begin
        valid = req0 | req1;
        idx   = P_CPU;
        // On contention the port that did not win last time gets the slot.
        if (req0 && req1) begin
            idx = ~last_grant;
        end else if (req1) begin
            idx = P_DBG;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Round-robin sharing of one memory port between the CPU and the
//           debug/loader port; issue, wait latency, then one-cycle ack.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

    if (!lat_ok(MEM_LAT)) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must lie in 1..7");
    end

    state_t              state_q, state_d;
    logic                gnt_q,   gnt_d;
    logic                last_q,  last_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wd_q,    wd_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                pick_valid;
    logic                pick_idx;
    logic                rd_done;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign rd_done = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= P_CPU;
            last_q  <= P_DBG;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (rd_done) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured at grant so the memory side never sees a
    // requester changing its inputs mid-access.
    always_comb begin
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        if ((state_q == ST_IDLE) && pick_valid) begin
            gnt_d  = pick_idx;
            last_d = pick_idx;
            we_d   = pick_idx ? we1    : we0;
            addr_d = pick_idx ? addr1  : addr0;
            wd_d   = pick_idx ? wdata1 : wdata0;
        end
        if ((state_q == ST_ACCESS) && !we_q) begin
            cnt_d = LAT_CNT;
        end
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (rd_done) begin
            rdata_d = mem_rdata;
        end
    end

    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_ACCESS: begin
                mem_addr = addr_q;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wd_q;
                end else begin
                    mem_re = 1'b1;
                end
            end
            ST_RESP: begin
                ack0 = (gnt_q == P_CPU);
                ack1 = (gnt_q == P_DBG);
            end
            default: ;
        endcase
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter (latency 1 and 3).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, busy, mem_re, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic       req0_b, we0_b, req1_b, we1_b;
    logic [7:0] addr0_b, wdata0_b, addr1_b, wdata1_b;
    logic       ack0_b, ack1_b, busy_b, mem_re_b, mem_we_b;
    logic [7:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT_A)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT_B)) dut_b (
        .clock(clock), .reset(reset),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b),
        .rdata(rdata_b), .busy(busy_b), .mem_re(mem_re_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h30:   return 8'hC3;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    // Memory macros: data appears exactly MEM_LAT cycles after the address.
    logic [7:0] mem_a [256];
    logic [7:0] pipe_a [LAT_A];
    logic [7:0] pipe_b [LAT_B];
    bit         mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(8'(i));
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem_a[mem_addr] <= mem_wdata;
        end
        pipe_a[0] <= mem_a[mem_addr];
        pipe_b[0] <= init_val(mem_addr_b);
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign mem_rdata   = pipe_a[LAT_A-1];
    assign mem_rdata_b = pipe_b[LAT_B-1];

    typedef struct packed {
        logic       port;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [256];
    int         n_vec = 0;
    int         n_err = 0;

    always @(negedge clock) begin
        if (!reset && (ack0 || ack1)) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_ack: ack0=%0b ack1=%0b, required no ack", ack0, ack1);
            end else begin
                mon_e = sb.pop_front();
                if ((ack0 && ack1) || (ack1 !== mon_e.port) || (mon_e.rd && rdata !== mon_e.data)) begin
                    n_err++;
                    $display("FAIL sb_ack: got ack0=%0b ack1=%0b rdata=%02h, required port=%0d rdata=%02h",
                             ack0, ack1, rdata, mon_e.port, mon_e.data);
                end
            end
        end
    end

    task automatic issue(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.rd   = !we;
        e.data = we ? 8'h00 : ref_mem[addr];
        if (we) ref_mem[addr] = data;
        sb.push_back(e);
        if (port == 1'b0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
        end
    endtask

    task automatic wait_ack(input bit port, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if ((port ? ack1 : ack0) === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        req0_b = 0; we0_b = 0; addr0_b = 0; wdata0_b = 0;
        req1_b = 0; we1_b = 0; addr1_b = 0; wdata1_b = 0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({ack0, ack1, busy, mem_re, mem_we} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: ack0,ack1,busy,re,we=%b, required 00000", {ack0, ack1, busy, mem_re, mem_we});
        end
        n_vec++;
        if ({rdata, mem_addr, mem_wdata} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_buses: rdata=%02h addr=%02h wdata=%02h, required 00 00 00", rdata, mem_addr, mem_wdata);
        end
        n_vec++;
        if ({ack0_b, ack1_b, busy_b, mem_re_b, mem_we_b, rdata_b} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_dut_b: flags=%b rdata=%02h, required all 0",
                     {ack0_b, ack1_b, busy_b, mem_re_b, mem_we_b}, rdata_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_p0;
        @(negedge clock);
        issue(1'b0, 1'b0, 8'h10, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            n_vec++;
            if (c == 1 && (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10)) begin
                n_err++;
                $display("FAIL read_issue: re=%b we=%b addr=%02h, required re=1 we=0 addr=10", mem_re, mem_we, mem_addr);
            end else if (ack1 !== 1'b0 || ack0 !== (c == 3)) begin
                n_err++;
                $display("FAIL read_ack_cycle%0d: ack0=%b ack1=%b, required ack0=%b ack1=0", c, ack0, ack1, (c == 3));
            end else if (c == 3 && rdata !== 8'hA5) begin
                n_err++;
                $display("FAIL read_data: rdata=%02h, required A5", rdata);
            end
            if (c == 3) req0 = 1'b0;
        end
    endtask

    task automatic test_write_p1;
        int lat;
        @(negedge clock);
        issue(1'b1, 1'b1, 8'h20, 8'h3C);
        @(negedge clock);
        n_vec++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin
            n_err++;
            $display("FAIL write_issue: we=%b re=%b addr=%02h wdata=%02h, required we=1 re=0 addr=20 wdata=3C",
                     mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clock);
        n_vec++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL write_ack: ack1=%b ack0=%b rdata=%02h, required ack1=1 ack0=0 rdata=A5", ack1, ack0, rdata);
        end
        req1 = 1'b0;
        @(negedge clock);
        issue(1'b0, 1'b0, 8'h20, 8'h00);
        wait_ack(1'b0, lat);
        n_vec++;
        if (lat != 2 + LAT_A || rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL readback: latency=%0d rdata=%02h, required latency=%0d rdata=3C", lat, rdata, 2 + LAT_A);
        end
        req0 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int gap;
        bit p;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        issue(1'b0, 1'b1, 8'h40, 8'h11);
        issue(1'b1, 1'b0, 8'h40, 8'h00);
        for (int k = 0; k < 4; k++) begin
            gap = -1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                if (ack0 === 1'b1 || ack1 === 1'b1) begin
                    gap = c;
                    break;
                end
            end
            p = ack1;
            n_vec++;
            if (gap < 0 || gap > 3 + LAT_A || p !== k[0]) begin
                n_err++;
                $display("FAIL rr_order_%0d: port=%0d gap=%0d, required port=%0d gap<=%0d", k, p, gap, k[0], 3 + LAT_A);
            end
            if (k == 0) issue(1'b0, 1'b0, 8'h41, 8'h00);
            else if (k == 1) issue(1'b1, 1'b1, 8'h42, 8'h77);
            else if (p) req1 = 1'b0;
            else req0 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_latency;
        @(negedge clock);
        req0_b = 1'b1; we0_b = 1'b0; addr0_b = 8'h30;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            n_vec++;
            if (busy_b !== (c <= 5) || mem_re_b !== (c == 1) || ack0_b !== (c == 5) || ack1_b !== 1'b0
                || (c == 5 && rdata_b !== 8'hC3)) begin
                n_err++;
                $display("FAIL lat3_cycle%0d: busy=%b re=%b ack0=%b ack1=%b rdata=%02h, required busy=%b re=%b ack0=%b ack1=0 rdata=C3",
                         c, busy_b, mem_re_b, ack0_b, ack1_b, rdata_b, (c <= 5), (c == 1), (c == 5));
            end
            if (c == 5) req0_b = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int   lat;
        exp_t e;
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h50; wdata0 = 8'h00;
        repeat (2) @(negedge clock);
        n_vec++;
        if (busy !== 1'b1 || ack0 !== 1'b0) begin
            n_err++;
            $display("FAIL pre_abort: busy=%b ack0=%b, required busy=1 ack0=0", busy, ack0);
        end
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_abort: re=%b we=%b busy=%b, required 0 0 0", mem_re, mem_we, busy);
        end
        repeat (2) begin
            @(negedge clock);
            n_vec++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_ack: ack0=%b ack1=%b, required 0 0", ack0, ack1);
            end
        end
        reset = 1'b0;
        e.port = 1'b0; e.rd = 1'b1; e.data = ref_mem[8'h50];
        sb.push_back(e);
        wait_ack(1'b0, lat);
        n_vec++;
        if (lat != 2 + LAT_A || rdata !== init_val(8'h50)) begin
            n_err++;
            $display("FAIL regrant: latency=%0d rdata=%02h, required latency=%0d rdata=%02h",
                     lat, rdata, 2 + LAT_A, init_val(8'h50));
        end
        req0 = 1'b0;
    endtask

    task automatic test_resp_handoff;
        int lat;
        @(negedge clock);
        issue(1'b0, 1'b1, 8'h60, 8'h99);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            n_vec++;
            if (mem_re === 1'b1 && mem_we === 1'b1) begin
                n_err++;
                $display("FAIL strobe_overlap_c%0d: re=%b we=%b, required not both 1", c, mem_re, mem_we);
            end else if (c == 2 && ack0 !== 1'b1) begin
                n_err++;
                $display("FAIL handoff_ack0: ack0=%b, required 1", ack0);
            end else if (c == 4 && (mem_re !== 1'b1 || mem_addr !== 8'h60)) begin
                n_err++;
                $display("FAIL handoff_grant: re=%b addr=%02h, required re=1 addr=60", mem_re, mem_addr);
            end
            if (c == 2) begin
                issue(1'b1, 1'b0, 8'h60, 8'h00);
                issue(1'b0, 1'b0, 8'h61, 8'h00);
            end
        end
        wait_ack(1'b1, lat);
        n_vec++;
        if (lat != 1 + LAT_A) begin
            n_err++;
            $display("FAIL handoff_p1_lat: latency=%0d, required %0d", lat, 1 + LAT_A);
        end
        req1 = 1'b0;
        wait_ack(1'b0, lat);
        n_vec++;
        if (lat != 3 + LAT_A) begin
            n_err++;
            $display("FAIL handoff_p0_lat: latency=%0d, required %0d", lat, 3 + LAT_A);
        end
        req0 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        test_reset();
        test_read_p0();
        test_write_p1();
        test_back_to_back();
        test_latency();
        test_reset_mid();
        test_resp_handoff();
        repeat (4) @(negedge clock);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d transactions outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: port 0 is the multicycle CPU control/datapath and port 1 is the debug/loader port.
- Performs round-robin arbitration and sequences each access as issue, wait for memory latency, then respond.
- Returns a one-cycle ack, plus registered read data, to the winning requester.
- Sits between the processor's memory address/data muxes and the memory macro. The CPU control FSM holds its memory-cycle state until ack.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_LAT, 1, cycles from mem_re to valid mem_rdata; legal values are 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 (CPU) request.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 transaction complete, one-cycle pulse.
- req1  in  1  port 1 (debug/loader) request.
- we1  in  1  port 1 write/read.
- addr1  in  ADDR_W  port 1 address.
- wdata1  in  DATA_W  port 1 write data.
- ack1  out  1  port 1 complete pulse.
- rdata  out  DATA_W  registered read data, valid in the ack cycle and held until the next read capture.
- busy  out  1  high in any state other than IDLE.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, named clock; reset is asynchronous and active-high, named reset.
- Reset values: all outputs 0, state=IDLE, rdata=0, last_grant=1 (so port 0 wins the first contention).
- Handshake:
  - A requester raises req with stable we/addr/wdata and holds all of them until it sees ack.
  - It deasserts req in the cycle after ack, or keeps it high to issue a new transaction.
  - Dropping req before ack is illegal; the arbiter still completes the access and pulses ack.
- Arbitration happens in IDLE only:
  - If only one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - The granted index and its we/addr/wdata are registered into gnt, we_r, addr_r, wd_r.
  - last_grant updates on every grant.
- State machine:
  - IDLE: if req0|req1, grant and go to ACCESS; otherwise stay in IDLE.
  - ACCESS: drive mem_addr=addr_r. If we_r: mem_we=1, mem_wdata=wd_r, next state RESP. Else: mem_re=1, load cnt=MEM_LAT, next state WAIT.
  - WAIT: cnt decrements each cycle. In the cycle cnt==1, rdata<=mem_rdata and next state is RESP.
  - RESP: ack[gnt]=1 for exactly one cycle, next state IDLE.
- Strobes: mem_re and mem_we are asserted only in ACCESS and are never both high. mem_addr and mem_wdata are 0 outside ACCESS.
- Latency, counted from the first cycle req is seen high in IDLE (cycle 0):
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+MEM_LAT.
  - Back-to-back transactions on one port have a minimum spacing of 3 cycles (write) or 3+MEM_LAT cycles (read), because RESP always returns through IDLE.
- Request timing: a req arriving in any non-IDLE state waits and is never lost, because req is held. A req arriving in RESP for the non-granted port wins in the following IDLE.
- rdata is not altered by writes.
- Simultaneous events: both reqs rising in the same IDLE cycle resolve by last_grant; no grant is issued outside IDLE.
- Reset mid-operation: the state returns to IDLE asynchronously, strobes drop immediately, and no ack is issued for the aborted transaction. Requesters must reissue.
- Width rules: cnt width is 3 bits. MEM_LAT outside 1..7 is a compile-time error.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=0, ACCESS=1, WAIT=2, RESP=3, 2 bits;
  - port index constants: P_CPU=0, P_DBG=1;
  - MEM_LAT bounds.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin selector with inputs req0, req1, last_grant and outputs valid, idx. It is instantiated once.

Test Plan:
- Reset, then req0=1, we0=0, addr0=8'h10, memory[10]=8'hA5, MEM_LAT=1: mem_re=1 in cycle 1 with mem_addr=8'h10; ack0=1 and rdata=8'hA5 in cycle 3; ack1 stays 0.
- req1 write, addr1=8'h20, wdata1=8'h3C: mem_we=1 in cycle 1; ack1 in cycle 2. A following port 0 read of 8'h20 returns 8'h3C.
- req0 and req1 both high from reset and held through several transactions: grants alternate 0,1,0,1; no port waits more than one other transaction.
- MEM_LAT=3, port 0 read: ack0 in cycle 5; busy high for cycles 1..5; mem_re high only in cycle 1.
- Assert reset during WAIT of a read: mem_re/mem_we=0 and busy=0 immediately, and no ack follows. After release, the held req0 is re-granted and completes normally.
- Port 0 write followed by a port 1 read, with req1 raised in the RESP cycle of port 0: port 1 is granted in the next IDLE; mem_re and mem_we are never high together.
